// File: rtl/packet_arbiter_pkg.sv
// Shared definitions for the packet arbiter slice.
//   arb_state_t : arbiter FSM state (ARB_IDLE, ARB_OWN)
//   CNT_W       : width of each per-requester packet counter
package pkg_compilare;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  localparam int unsigned CNT_W = 16;

endpackage : pkg_compilare

// File: rtl/packet_arbiter_rr_pick.sv
// Round-robin winner search (purely combinational).
// Picks the first set request at or above i_ptr, wrapping from N_REQ-1 to 0.
// Ports:
//   i_req   : request vector
//   i_ptr   : search start index
//   o_grant : one-hot winner (all zero when no request)
//   o_found : any request present
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_found
);

  logic [N_REQ-1:0] w_hi;
  logic [N_REQ-1:0] w_src;
  logic             w_done;

  // Requests at or above the pointer take priority; if there are none,
  // the lowest request overall is next in wrap-around order.
  always_comb begin
    w_hi = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_hi[i] = i_req[i] & (PTR_W'(i) >= i_ptr);
    end
    w_src   = (|w_hi) ? w_hi : i_req;
    o_grant = '0;
    w_done  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_src[i] && !w_done) begin
        o_grant[i] = 1'b1;
        w_done     = 1'b1;
      end
    end
  end

  assign o_found = |i_req;

endmodule : rr_pick

// File: rtl/packet_arbiter.sv
// Packet arbiter: N_REQ packet sources share one output channel.
// A winner is chosen round-robin while idle and then owns the channel
// until its last beat transfers; the owner's beat path is combinational.
// Ports:
//   clk, rst             : clock, async active-high reset
//   in_valid/data/last   : per-requester beat inputs
//   in_ready             : per-requester accept (owner only, = out_ready)
//   out_valid/data/last  : shared channel beat
//   out_ready            : downstream accept
//   grant                : one-hot owner, zero when idle
//   busy                 : a packet is owned
//   pkt_cnt              : per-requester completed-packet counters, present
//                          only when PACKET_ARBITER_STATS_EN is defined
module packet_arbiter
  import pkg_compilare::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          in_valid,
  input  logic [N_REQ*DATA_W-1:0]   in_data,
  input  logic [N_REQ-1:0]          in_last,
  output logic [N_REQ-1:0]          in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy
`ifdef PACKET_ARBITER_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]    pkt_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W-1:0] w_owner;
  logic [N_REQ-1:0] w_pick_grant;
  logic             w_pick_found;
  logic             w_last_xfer;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_found (w_pick_found)
  );

  // Binary index of the current owner, used to advance the pointer.
  always_comb begin
    w_owner = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) w_owner = PTR_W'(i);
    end
  end

  // Owner's beat path straight through; everything quiet while idle.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    in_ready  = '0;
    if (r_state == ARB_OWN) begin
      out_valid = |(in_valid & r_grant);
      out_last  = |(in_last & r_grant);
      in_ready  = r_grant & {N_REQ{out_ready}};
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (r_grant[i]) out_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant       = r_grant;
  assign busy        = (r_state == ARB_OWN);
  assign w_last_xfer = out_valid & out_ready & out_last;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = ARB_OWN;
          w_grant_nxt = w_pick_grant;
        end
      end
      ARB_OWN: begin
        if (w_last_xfer) begin
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = (w_owner == PTR_W'(N_REQ - 1)) ? '0 : w_owner + PTR_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

`ifdef PACKET_ARBITER_STATS_EN
  logic [CNT_W-1:0] r_cnt [N_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else if (w_last_xfer) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (r_grant[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pkt_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
    end
  end
`endif

endmodule : packet_arbiter

// File: tb/tb_packet_arbiter.sv
module tb_packet_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_last = '0;
  logic            out_ready = 1'b0;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef PACKET_ARBITER_STATS_EN
  logic [N*16-1:0] pkt_cnt;
`endif

  packet_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .grant(grant), .busy(busy)
`ifdef PACKET_ARBITER_STATS_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: owner index (-1 idle), rotating start pointer,
  // per-requester completed-packet counts.
  int           m_owner = -1;
  int           m_ptr   = 0;
  logic [15:0]  m_cnt [N];
  int           cyc = 0;
  logic [N-1:0] acc = '0;
  logic [N-1:0] prev_grant = '0;
  logic [DW-1:0] xq[$];
  int           glog_t[$];
  logic [N-1:0] glog_g[$];

  initial for (int i = 0; i < N; i++) m_cnt[i] = '0;

  // Inputs only change at posedge+1, so values seen here are those the next edge samples.
  always @(negedge clk) begin : cmp
    logic [N-1:0]  e_grant, e_rdy;
    logic          e_busy, e_valid, e_last;
    logic [DW-1:0] e_data;
    bit            found;
    int            idx;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
    end
    e_grant = '0; e_rdy = '0; e_busy = 0; e_valid = 0; e_last = 0; e_data = '0;
    if (!rst && m_owner >= 0) begin
      e_grant = 4'b0001 << m_owner;
      e_busy  = 1'b1;
      e_valid = in_valid[m_owner];
      e_last  = in_last[m_owner];
      e_data  = in_data[m_owner*DW +: DW];
      e_rdy   = out_ready ? e_grant : '0;
    end
    chk("grant", grant, e_grant);
    chk("busy", busy, e_busy);
    chk("out_valid", out_valid, e_valid);
    chk("out_last", out_last, e_last);
    chk("out_data", out_data, e_data);
    chk("in_ready", in_ready, e_rdy);
`ifdef PACKET_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) chk("pkt_cnt", pkt_cnt[i*16 +: 16], m_cnt[i]);
`endif
    acc = in_valid & in_ready;
    if (out_valid && out_ready) xq.push_back(out_data);
    if (grant != prev_grant && grant != '0) begin
      glog_t.push_back(cyc);
      glog_g.push_back(grant);
    end
    prev_grant = grant;
    if (!rst) begin
      if (m_owner < 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && in_valid[idx]) begin
            found   = 1;
            m_owner = idx;
          end
        end
      end else if (in_valid[m_owner] && out_ready && in_last[m_owner]) begin
        m_cnt[m_owner] = m_cnt[m_owner] + 16'd1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_grant"}, grant, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_ovalid"}, out_valid, 0);
    chk({nm, "_olast"}, out_last, 0);
    chk({nm, "_odata"}, out_data, 0);
    chk({nm, "_iready"}, in_ready, 0);
  endtask

  int           rem [N];
  logic [7:0]   seq [N];
  logic [N-1:0] eo [5];

  task automatic rand_drive();
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        rem[i] = rem[i] - 1;
        seq[i] = seq[i] + 8'd1;
      end
      if (rst) rem[i] = 0;
      if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 4);
      in_valid[i] = (rem[i] > 0) && ($urandom_range(0, 4) != 0);
      in_last[i]  = (rem[i] == 1);
      in_data[i*DW +: DW] = seq[i] + 8'(i * 64);
    end
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    eo[0] = 4'b0001; eo[1] = 4'b0010; eo[2] = 4'b0100; eo[3] = 4'b1000; eo[4] = 4'b0001;
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = '0; end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("rst");
    rst = 1'b0;

    // req 0: three-beat packet
    in_valid = 4'b0001; in_data[7:0] = 8'h11; in_last = '0; out_ready = 1'b1;
    #1 chk("r22_lat", grant, 0);
    step();
    chk("r22_grant", grant, 4'b0001);
    chk("r22_d0", out_data, 8'h11);
    step();
    in_data[7:0] = 8'h22;
    #1 chk("r22_d1", out_data, 8'h22);
    step();
    in_data[7:0] = 8'h33; in_last = 4'b0001;
    #1 chk("r22_d2", out_data, 8'h33);
    chk("r22_last", out_last, 1);
    step();
    in_valid = '0; in_last = '0;
    #1 chk("r22_busy", busy, 0);

    // req 2 with downstream stalls
    xq.delete();
    in_valid = 4'b0100; in_data[23:16] = 8'hA0; out_ready = 1'b1;
    step();
    chk("r24_grant", grant, 4'b0100);
    chk("r24_d0", out_data, 8'hA0);
    chk("r24_rdy0", in_ready, 4'b0100);
    step();
    in_data[23:16] = 8'hA1; out_ready = 1'b0;
    #1 chk("r24_hold1", out_data, 8'hA1);
    chk("r24_rdy1", in_ready, 4'b0000);
    step();
    #1 chk("r24_hold2", out_data, 8'hA1);
    chk("r24_busy2", busy, 1);
    step();
    out_ready = 1'b1;
    #1 chk("r24_d1", out_data, 8'hA1);
    chk("r24_rdy3", in_ready, 4'b0100);
    step();
    in_data[23:16] = 8'hA2; in_last = 4'b0100;
    step();
    in_valid = '0; in_last = '0;
    #1 chk("r24_busy", busy, 0);
    chk("r24_nbeats", xq.size(), 3);
    if (xq.size() == 3) begin
      chk("r24_x0", xq[0], 8'hA0);
      chk("r24_x1", xq[1], 8'hA1);
      chk("r24_x2", xq[2], 8'hA2);
    end

    // reset mid-packet on req 1; pointer currently sits at 3
    in_valid = 4'b0010; in_data[15:8] = 8'hB0; out_ready = 1'b1;
    step();
    chk("r25_own", grant, 4'b0010);
    step();
    in_data[15:8] = 8'hB1;
    rst = 1'b1;
    #1 chk_quiet("r25_rst");
    step();
    rst = 1'b0; in_valid = 4'b1010; in_data[31:24] = 8'hC0;
    #1 chk("r25_idle", grant, 0);
    step();
    chk("r25_win", grant, 4'b0010);

    // all four requesting continuously with two-beat packets
    rst = 1'b1; in_valid = '0;
    step();
    rst = 1'b0;
    glog_t.delete(); glog_g.delete();
    in_valid = 4'b1111; in_last = '0; out_ready = 1'b1;
    for (int c = 0; c < 40 && glog_g.size() < 5; c++) begin
      step();
      for (int i = 0; i < N; i++) if (acc[i]) in_last[i] = ~in_last[i];
    end
    chk("r23_ngrants", glog_g.size(), 5);
    for (int k = 0; k < 5 && k < glog_g.size(); k++) begin
      chk("r23_order", glog_g[k], eo[k]);
      if (k > 0) chk("r23_spacing", glog_t[k] - glog_t[k-1], 3);
    end

    // req 3: five single-beat packets
    rst = 1'b1; in_valid = '0; in_last = '0;
    step();
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      in_valid = 4'b1000; in_last = 4'b1000; in_data[31:24] = 8'(p + 8'h50); out_ready = 1'b1;
      step();
      chk("r12_grant", grant, 4'b1000);
      chk("r12_last", out_last, 1);
      step();
      in_valid = '0; in_last = '0;
      #1 chk("r12_done", busy, 0);
    end
`ifdef PACKET_ARBITER_STATS_EN
    chk("r26_cnt3", pkt_cnt[63:48], 16'd5);
    chk("r26_cnt0", pkt_cnt[15:0], 16'd0);
    chk("r26_cnt1", pkt_cnt[31:16], 16'd0);
    chk("r26_cnt2", pkt_cnt[47:32], 16'd0);
`endif

    // randomized traffic with occasional resets
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      rand_drive();
    end
    rst = 1'b0; in_valid = '0;
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_packet_arbiter

// File: doc/packet_arbiter.md
PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N_REQ, 4, number of requesters (2..8).
  DATA_W, 8, payload width per beat.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single clock; all logic on rising edge.
  rst  input  1  reset, asynchronous, active-high.
  in_valid  input  N_REQ  per-requester beat valid.
  in_data  input  N_REQ*DATA_W  per-requester payload; requester i in bits [i*DATA_W +: DATA_W].
  in_last  input  N_REQ  per-requester end-of-packet marker.
  in_ready  output  N_REQ  per-requester beat accepted.
  out_valid  output  1  shared channel beat valid.
  out_data  output  DATA_W  shared channel payload.
  out_last  output  1  shared channel end-of-packet.
  out_ready  input  1  downstream accepts beat.
  grant  output  N_REQ  one-hot current owner; all zero when idle.
  busy  output  1  high while a packet is owned.
REQ-003 A beat SHALL transfer on a channel when valid and ready are both high on a rising clk edge.

Function
REQ-004 FSM states SHALL be IDLE and OWN.
REQ-005 In IDLE: grant=0, busy=0, out_valid=0, and all in_ready=0.
REQ-006 In IDLE with any in_valid high, the winner SHALL be the first set in_valid searching upward from rr_ptr, wrapping N_REQ-1 to 0.
REQ-007 The winner SHALL be registered into grant, and the FSM SHALL enter OWN on the next edge; request-to-grant latency is 1 cycle.
REQ-008 In OWN, for owner g: out_valid=in_valid[g], out_data=in_data[g], out_last=in_last[g], in_ready[g]=out_ready; all other in_ready SHALL be 0. These are combinational, with zero added latency.
REQ-009 Ownership SHALL be held across all beats, including cycles where in_valid[g]=0, until a beat with out_last=1 transfers.
REQ-010 On the last-beat transfer: FSM to IDLE, grant to 0, rr_ptr to (g+1) mod N_REQ. There is a 1-cycle IDLE bubble between consecutive packets.
REQ-011 rr_ptr SHALL change only on last-beat transfers.
REQ-012 A single-beat packet (in_last=1 on its first beat) SHALL complete in OWN within one cycle when out_ready=1.
REQ-013 Requests arriving during OWN SHALL be ignored until IDLE is re-entered; no requester is starved for more than N_REQ-1 packets.
REQ-014 With out_ready=0 in OWN, all outputs SHALL hold; no beat is lost or duplicated.

Reset
REQ-015 Asserting rst at any time SHALL immediately force IDLE, grant=0, busy=0, out_valid=0, out_last=0, out_data=0, in_ready=0, rr_ptr=0, and all counters to 0.
REQ-016 A packet in progress at reset SHALL be abandoned; arbitration restarts from requester 0 after rst deasserts.

Configuration
REQ-017 Macro PACKET_ARBITER_STATS_EN, when defined, SHALL add output pkt_cnt (N_REQ*16 bits; requester i in [i*16 +: 16]).
REQ-018 pkt_cnt[i] SHALL count last-beat transfers of requester i and wrap from 65535 to 0.
REQ-019 Without the macro, the pkt_cnt port and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-020 Package pkg_compilare SHALL hold the FSM state enum (ARB_IDLE, ARB_OWN) and the constant for counter width 16.
REQ-021 The round-robin winner search SHALL be one combinational sub-module, rr_pick: inputs are the request vector and pointer; outputs are the one-hot winner and a found flag.

Verification
REQ-022 Req 0 sends a 3-beat packet (0x11,0x22,0x33), out_ready=1 -> grant=0001 one cycle after in_valid, out_data 0x11/0x22/0x33 on consecutive cycles, busy=0 after the last beat.
REQ-023 All 4 requesters valid continuously with 2-beat packets -> grant order 0,1,2,3,0 with exactly one IDLE cycle between packets.
REQ-024 Req 2 owns the channel, out_ready toggles 1,0,0,1 -> out_data holds during stalls, in_ready[2] follows out_ready, no beat is duplicated.
REQ-025 rst is pulsed mid-packet on req 1 -> outputs are 0 in the same cycle; after release, with req 1 and req 3 valid, req 1 wins (rr_ptr=0).
REQ-026 With PACKET_ARBITER_STATS_EN, req 3 sends 5 single-beat packets -> pkt_cnt[3]=5 and other counters=0; without the macro, the design compiles with no pkt_cnt port.
